// File: rtl/cache_ctrl_wb_if.sv
// Core and memory ports of the write-back cache controller, plus a state debug tap.
// Every *_valid/*_ready pair transfers when both are high at a rising clk_in edge; the
// payload is held stable while valid waits for ready. Core responses have no ready.
interface cache_ctrl_wb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req_valid_in;
  logic              core_req_ready_out;
  logic              core_req_we_in;
  logic [ADDR_W-1:0] core_req_addr_in;
  logic [DATA_W-1:0] core_req_wdata_in;
  logic              core_resp_valid_out;
  logic [DATA_W-1:0] core_resp_rdata_out;
  logic              mem_req_valid_out;
  logic              mem_req_ready_in;
  logic              mem_req_we_out;
  logic [ADDR_W-1:0] mem_req_addr_out;
  logic [DATA_W-1:0] mem_req_wdata_out;
  logic              mem_resp_valid_in;
  logic [DATA_W-1:0] mem_resp_rdata_in;
  logic [2:0]        state_dbg;

  modport slave (
    input  core_req_valid_in, core_req_we_in, core_req_addr_in, core_req_wdata_in,
           mem_req_ready_in, mem_resp_valid_in, mem_resp_rdata_in,
    output core_req_ready_out, core_resp_valid_out, core_resp_rdata_out,
           mem_req_valid_out, mem_req_we_out, mem_req_addr_out, mem_req_wdata_out,
           state_dbg
  );

  modport master (
    output core_req_valid_in, core_req_we_in, core_req_addr_in, core_req_wdata_in,
           mem_req_ready_in, mem_resp_valid_in, mem_resp_rdata_in,
    input  core_req_ready_out, core_resp_valid_out, core_resp_rdata_out,
           mem_req_valid_out, mem_req_we_out, mem_req_addr_out, mem_req_wdata_out,
           state_dbg
  );
endinterface

// File: rtl/cache_ctrl_wb.sv
// N-way set-associative write-back/write-allocate cache controller, one word per line, true LRU.
// Optional hit/miss/writeback counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl_wb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6,
  parameter int WAYS    = 4
) (
  input  logic           clk_in,
  input  logic           reset_in,
  cache_ctrl_wb_if.slave bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]    hit_cnt_out,
  output logic [31:0]    miss_cnt_out,
  output logic [31:0]    wb_cnt_out
`endif
);
  localparam int AW    = $clog2(WAYS);
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESP, S_WB, S_FILL_REQ, S_FILL_WAIT, S_INSTALL
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-3:0]   req_word_q, req_word_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [AW-1:0]       victim_q, victim_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;

  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [DATA_W-1:0]   data_q  [SETS][WAYS];
  logic                valid_q [SETS][WAYS];
  logic                dirty_q [SETS][WAYS];
  logic [AW-1:0]       age_q   [SETS][WAYS];

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit, has_inv;
  logic [AW-1:0]       hit_way, inv_way, old_way, vict;

  logic                arr_we, arr_dirty, lru_upd;
  logic [AW-1:0]       arr_way, lru_way;
  logic [DATA_W-1:0]   arr_data;

  assign idx     = req_word_q[INDEX_W-1:0];
  assign req_tag = req_word_q[ADDR_W-3:INDEX_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    old_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
      if (!valid_q[idx][w] && !has_inv) begin
        has_inv = 1'b1;
        inv_way = AW'(w);
      end
      if (age_q[idx][w] == AW'(WAYS-1)) old_way = AW'(w);
    end
  end

  assign vict = has_inv ? inv_way : old_way;

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    req_we_d     = req_we_q;
    req_word_d   = req_word_q;
    req_wdata_d  = req_wdata_q;
    victim_d     = victim_q;
    fill_data_d  = fill_data_q;
    arr_we       = 1'b0;
    arr_way      = '0;
    arr_data     = '0;
    arr_dirty    = 1'b0;
    lru_upd      = 1'b0;
    lru_way      = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.core_req_valid_in && ready_q) begin
          req_we_d    = bus.core_req_we_in;
          req_word_d  = bus.core_req_addr_in[ADDR_W-1:2];
          req_wdata_d = bus.core_req_wdata_in;
          ready_d     = 1'b0;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          lru_upd      = 1'b1;
          lru_way      = hit_way;
          arr_we       = req_we_q;
          arr_way      = hit_way;
          arr_data     = req_wdata_q;
          arr_dirty    = 1'b1;
          resp_rdata_d = req_we_q ? '0 : data_q[idx][hit_way];
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          victim_d = vict;
          if (valid_q[idx][vict] && dirty_q[idx][vict]) begin
            mem_valid_d = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx][vict], idx, 2'b00};
            mem_wdata_d = data_q[idx][vict];
            state_d     = S_WB;
          end else if (!req_we_q) begin
            mem_valid_d = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {req_word_q, 2'b00};
            state_d     = S_FILL_REQ;
          end else begin
            state_d = S_INSTALL;
          end
        end
      end
      S_WB: begin
        if (bus.mem_req_ready_in) begin
          if (req_we_q) begin
            mem_valid_d = 1'b0;
            mem_we_d    = 1'b0;
            state_d     = S_INSTALL;
          end else begin
            // Fill request goes out right behind the writeback, valid never dips.
            mem_we_d   = 1'b0;
            mem_addr_d = {req_word_q, 2'b00};
            state_d    = S_FILL_REQ;
          end
        end
      end
      S_FILL_REQ: begin
        if (bus.mem_req_ready_in) begin
          mem_valid_d = 1'b0;
          state_d     = S_FILL_WAIT;
        end
      end
      S_FILL_WAIT: begin
        if (bus.mem_resp_valid_in) begin
          fill_data_d = bus.mem_resp_rdata_in;
          state_d     = S_INSTALL;
        end
      end
      S_INSTALL: begin
        arr_we       = 1'b1;
        arr_way      = victim_q;
        arr_data     = req_we_q ? req_wdata_q : fill_data_q;
        arr_dirty    = req_we_q;
        lru_upd      = 1'b1;
        lru_way      = victim_q;
        resp_rdata_d = req_we_q ? '0 : fill_data_q;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      req_we_q     <= 1'b0;
      req_word_q   <= '0;
      req_wdata_q  <= '0;
      victim_q     <= '0;
      fill_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      req_we_q     <= req_we_d;
      req_word_q   <= req_word_d;
      req_wdata_q  <= req_wdata_d;
      victim_q     <= victim_d;
      fill_data_q  <= fill_data_d;
    end
  end

  // Line arrays; LRU ages restart as age[w]=w so they begin as a permutation.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AW'(w);
        end
      end
    end else begin
      if (arr_we) begin
        tag_q[idx][arr_way]   <= req_tag;
        data_q[idx][arr_way]  <= arr_data;
        valid_q[idx][arr_way] <= 1'b1;
        dirty_q[idx][arr_way] <= arr_dirty;
      end
      if (lru_upd) begin
        for (int w = 0; w < WAYS; w++) begin
          if (lru_way == AW'(w)) begin
            age_q[idx][w] <= '0;
          end else if (valid_q[idx][w] && age_q[idx][w] < age_q[idx][lru_way]) begin
            age_q[idx][w] <= age_q[idx][w] + AW'(1);
          end
        end
      end
    end
  end

  assign bus.core_req_ready_out  = ready_q;
  assign bus.core_resp_valid_out = resp_valid_q;
  assign bus.core_resp_rdata_out = resp_rdata_q;
  assign bus.mem_req_valid_out   = mem_valid_q;
  assign bus.mem_req_we_out      = mem_we_q;
  assign bus.mem_req_addr_out    = mem_addr_q;
  assign bus.mem_req_wdata_out   = mem_wdata_q;
  assign bus.state_dbg           = state_q;

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == S_LOOKUP) begin
      if (hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      if (!hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
    end
    if (state_q == S_WB && bus.mem_req_ready_in && wb_cnt_q != 32'hFFFF_FFFF)
      wb_cnt_d = wb_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt_out  = hit_cnt_q;
  assign miss_cnt_out = miss_cnt_q;
  assign wb_cnt_out   = wb_cnt_q;
`endif
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed bench for cache_ctrl_wb: vector tables per phase plus hand sequences for
// writeback stall and reset during a fill.
module tb_cache_ctrl_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_ctrl_wb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  cache_ctrl_wb #(.ADDR_W(32), .DATA_W(32), .INDEX_W(6), .WAYS(4)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_cnt_out  (hit_cnt),
    .miss_cnt_out (miss_cnt),
    .wb_cnt_out   (wb_cnt)
`endif
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_fills;
    int          exp_wbs;
    logic [31:0] exp_fill_addr;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_data;
    int          exp_lat;   // 0 = latency not checked
    int          stall;     // cycles memory holds ready low on the first request
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model; unwritten words read as addr ^ 0x5A5A0000.
  logic [31:0] mem_m [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  int          stall_cnt  = 0;
  bit          fill_block = 0;
  int          wb_seen    = 0;
  int          fill_seen  = 0;
  logic [31:0] wb_addr_seen, wb_data_seen, fill_addr_seen;
  bit          hs_we;
  logic [31:0] hs_addr;
  bit          snap_ok = 0;
  logic [31:0] snap_addr, snap_data;

  // Memory responder: raises ready for one cycle, returns fill data the cycle after.
  always @(negedge clk) begin
    bus.mem_resp_valid_in = 1'b0;
    if (rst) begin
      bus.mem_req_ready_in  = 1'b0;
      bus.mem_resp_rdata_in = '0;
      snap_ok = 0;
    end else if (bus.mem_req_ready_in) begin
      bus.mem_req_ready_in = 1'b0;
      if (!hs_we && !fill_block) begin
        bus.mem_resp_valid_in = 1'b1;
        bus.mem_resp_rdata_in = mem_rd(hs_addr);
      end
    end else if (bus.mem_req_valid_out) begin
      if (stall_cnt > 0) begin
        if (!snap_ok) begin
          snap_ok   = 1;
          snap_addr = bus.mem_req_addr_out;
          snap_data = bus.mem_req_wdata_out;
        end else begin
          check("stall_addr", bus.mem_req_addr_out, snap_addr);
          check("stall_wdata", bus.mem_req_wdata_out, snap_data);
          check("stall_we", 32'(bus.mem_req_we_out), 32'd1);
        end
        check("stall_no_resp", 32'(bus.core_resp_valid_out), 32'd0);
        stall_cnt--;
      end else begin
        bus.mem_req_ready_in = 1'b1;
        hs_we   = bus.mem_req_we_out;
        hs_addr = bus.mem_req_addr_out;
        snap_ok = 0;
        if (hs_we) begin
          wb_seen++;
          wb_addr_seen = hs_addr;
          wb_data_seen = bus.mem_req_wdata_out;
          mem_m[hs_addr] = bus.mem_req_wdata_out;
        end else begin
          fill_seen++;
          fill_addr_seen = hs_addr;
        end
      end
    end
  end

  // Response scoreboard: every pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && bus.core_resp_valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        check("resp_rdata", bus.core_resp_rdata_out, exp_q.pop_front());
      end
    end
  end

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, output int lat);
    int n;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    bus.core_req_valid_in = 1'b1;
    bus.core_req_we_in    = we;
    bus.core_req_addr_in  = addr;
    bus.core_req_wdata_in = wdata;
    n = 0;
    while (!bus.core_req_ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.core_req_valid_in = 1'b0;
    lat = 1;
    while (!bus.core_resp_valid_out && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.core_resp_valid_out) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: addr 0x%08h no response after %0d cycles", addr, lat);
      void'(exp_q.pop_back());
    end
    @(negedge clk);
    check("resp_one_cycle", 32'(bus.core_resp_valid_out), 32'd0);
    check("ready_after_resp", 32'(bus.core_req_ready_out), 32'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    wb_seen   = 0;
    fill_seen = 0;
    stall_cnt = v.stall;
    do_req(v.we, v.addr, v.wdata, v.exp_rdata, lat);
    check({tag, "_fills"}, fill_seen, v.exp_fills);
    check({tag, "_wbs"}, wb_seen, v.exp_wbs);
    if (v.exp_fills > 0) check({tag, "_fill_addr"}, fill_addr_seen, v.exp_fill_addr);
    if (v.exp_wbs > 0) begin
      check({tag, "_wb_addr"}, wb_addr_seen, v.exp_wb_addr);
      check({tag, "_wb_data"}, wb_data_seen, v.exp_wb_data);
    end
    if (v.exp_lat > 0) check({tag, "_lat"}, lat, v.exp_lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t va[8];
  vec_t vb[15];

  initial begin
    int n;
    bus.core_req_valid_in = 1'b0;
    bus.core_req_we_in    = 1'b0;
    bus.core_req_addr_in  = '0;
    bus.core_req_wdata_in = '0;
    mem_m[32'h100] = 32'hDEAD_BEEF;

    //         we addr    wdata   exp_rdata     fl wb fill_addr wb_addr wb_data lat stall
    va[0] = '{0, 32'h100, 32'h0,  32'hDEADBEEF, 1, 0, 32'h100, 32'h0, 32'h0, 0, 0};
    va[1] = '{0, 32'h100, 32'h0,  32'hDEADBEEF, 0, 0, 32'h0,   32'h0, 32'h0, 2, 0};
    va[2] = '{1, 32'h200, 32'h11, 32'h0,        0, 0, 32'h0,   32'h0, 32'h0, 0, 0};
    va[3] = '{0, 32'h200, 32'h0,  32'h11,       0, 0, 32'h0,   32'h0, 32'h0, 2, 0};
    va[4] = '{0, 32'h104, 32'h0,  32'h5A5A0104, 1, 0, 32'h104, 32'h0, 32'h0, 0, 0};
    va[5] = '{1, 32'h104, 32'h77, 32'h0,        0, 0, 32'h0,   32'h0, 32'h0, 2, 0};
    va[6] = '{0, 32'h104, 32'h0,  32'h77,       0, 0, 32'h0,   32'h0, 32'h0, 2, 0};
    va[7] = '{0, 32'h107, 32'h0,  32'h77,       0, 0, 32'h0,   32'h0, 32'h0, 2, 0};

    vb[0]  = '{1, 32'h000, 32'hCAFE0000, 32'h0,   0, 0, 32'h0,   32'h0,   32'h0,        0, 0};
    vb[1]  = '{0, 32'h100, 32'h0, 32'hDEADBEEF,   1, 0, 32'h100, 32'h0,   32'h0,        0, 0};
    vb[2]  = '{0, 32'h200, 32'h0, 32'h5A5A0200,   1, 0, 32'h200, 32'h0,   32'h0,        0, 0};
    vb[3]  = '{0, 32'h300, 32'h0, 32'h5A5A0300,   1, 0, 32'h300, 32'h0,   32'h0,        0, 0};
    vb[4]  = '{0, 32'h100, 32'h0, 32'hDEADBEEF,   0, 0, 32'h0,   32'h0,   32'h0,        2, 0};
    vb[5]  = '{0, 32'h200, 32'h0, 32'h5A5A0200,   0, 0, 32'h0,   32'h0,   32'h0,        2, 0};
    vb[6]  = '{0, 32'h300, 32'h0, 32'h5A5A0300,   0, 0, 32'h0,   32'h0,   32'h0,        2, 0};
    vb[7]  = '{0, 32'h400, 32'h0, 32'h5A5A0400,   1, 1, 32'h400, 32'h000, 32'hCAFE0000, 0, 0};
    vb[8]  = '{1, 32'h500, 32'h55, 32'h0,         0, 0, 32'h0,   32'h0,   32'h0,        0, 0};
    vb[9]  = '{0, 32'h200, 32'h0, 32'h5A5A0200,   0, 0, 32'h0,   32'h0,   32'h0,        2, 0};
    vb[10] = '{0, 32'h300, 32'h0, 32'h5A5A0300,   0, 0, 32'h0,   32'h0,   32'h0,        2, 0};
    vb[11] = '{0, 32'h400, 32'h0, 32'h5A5A0400,   0, 0, 32'h0,   32'h0,   32'h0,        2, 0};
    vb[12] = '{1, 32'h600, 32'h66, 32'h0,         0, 1, 32'h0,   32'h500, 32'h55,       0, 5};
    vb[13] = '{0, 32'h600, 32'h0, 32'h66,         0, 0, 32'h0,   32'h0,   32'h0,        2, 0};
    vb[14] = '{0, 32'h500, 32'h0, 32'h55,         1, 0, 32'h500, 32'h0,   32'h0,        0, 0};

    #12;
    check("rst_ready", 32'(bus.core_req_ready_out), 32'd1);
    check("rst_resp_valid", 32'(bus.core_resp_valid_out), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_req_valid_out), 32'd0);
    check("rst_mem_addr", bus.mem_req_addr_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("a%0d", i), va[i]);

    do_reset();
    for (int i = 0; i < 15; i++) run_vec($sformatf("b%0d", i), vb[i]);
`ifdef CACHE_CTRL_STATS_EN
    check("stat_hits", hit_cnt, 32'd7);
    check("stat_misses", miss_cnt, 32'd8);
    check("stat_wbs", wb_cnt, 32'd2);
`endif

    // Reset while the controller waits for fill data.
    do_reset();
    fill_block = 1;
    fill_seen  = 0;
    @(negedge clk);
    bus.core_req_valid_in = 1'b1;
    bus.core_req_we_in    = 1'b0;
    bus.core_req_addr_in  = 32'h700;
    @(negedge clk);
    bus.core_req_valid_in = 1'b0;
    n = 0;
    while (fill_seen == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rf_fill_issued", fill_seen, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rf_ready", 32'(bus.core_req_ready_out), 32'd1);
    check("rf_resp_valid", 32'(bus.core_resp_valid_out), 32'd0);
    check("rf_resp_rdata", bus.core_resp_rdata_out, 32'd0);
    check("rf_mem_valid", 32'(bus.mem_req_valid_out), 32'd0);
    check("rf_mem_we", 32'(bus.mem_req_we_out), 32'd0);
    check("rf_mem_addr", bus.mem_req_addr_out, 32'd0);
    check("rf_mem_wdata", bus.mem_req_wdata_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fill_block = 0;
    run_vec("rf_reload", '{0, 32'h700, 32'h0, 32'h5A5A0700, 1, 0, 32'h700, 32'h0, 32'h0, 0, 0});

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
